mbyte_add_seq: RTL and testbench
================================

# mbyte_add_seq

Multi-byte add/subtract sequencer. It computes NBYTES-wide sums and differences by time-multiplexing one internal cla_8bit instance, one byte per clock, with the carry registered between bytes. It sits between an operand producer and a result consumer, each with a valid/ready handshake. It is the serial, area-lean alternative to a full-width carry-lookahead adder.

## Interface
- NBYTES, 4: operand width in bytes; legal range 2..16. Datapath width W = 8*NBYTES.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  input  1  operand-side request.
- in_ready  output  1  block can accept operands; high only in IDLE.
- op_a  input  W  operand A, unsigned or two's complement.
- op_b  input  W  operand B.
- sub  input  1  0 computes A+B; 1 computes A−B, as A + ~B + 1.
- out_valid  output  1  result, cout and ovf are valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- result  output  W  sum or difference, modulo 2^W.
- cout  output  1  carry out of bit W−1. For subtraction, 1 means no borrow.
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN or DONE.

## Operation
- FSM has three states: IDLE, RUN, DONE.
- IDLE, on in_valid && in_ready:
  - latch op_a into a_reg;
  - latch B_eff into b_reg, where B_eff = sub ? ~op_b : op_b;
  - set carry_reg = sub and idx = 0;
  - go to RUN.
- RUN, each cycle:
  - the cla_8bit inputs are a_reg[8*idx +: 8], b_reg[8*idx +: 8] and Cin = carry_reg;
  - its Sum is written to res_reg[8*idx +: 8] and its Cout to carry_reg;
  - idx increments.
- When idx == NBYTES−1 the last byte is written and the FSM goes to DONE on the same edge.
  - cout_reg takes the final Cout.
  - ovf_reg = (a_reg[W−1] == b_reg[W−1]) && (Sum[7] != a_reg[W−1]). This uses the inverted B for subtraction.
- DONE: out_valid = 1. result, cout and ovf are held stable until out_valid && out_ready, then the FSM goes to IDLE.
- in_ready = (state == IDLE). Operand changes while the FSM is not in IDLE are ignored.
- idx is ceil(log2(NBYTES)) bits wide and never exceeds NBYTES−1.
- Reset (rst_n == 0 at a clock edge), from any state:
  - state = IDLE, idx = 0, carry_reg = 0, res_reg = 0, cout_reg = 0, ovf_reg = 0;
  - any in-flight operation is discarded and produces no output.
- Reset values of outputs: in_ready = 1, out_valid = 0, busy = 0, result = 0, cout = 0, ovf = 0.
- There is no abort input and no pipelining: at most one operation is in flight.

## Timing
- Accept edge T0, where in_valid && in_ready is sampled high.
- Bytes 0..NBYTES−1 are written on edges T1..T_NBYTES.
- out_valid rises after edge T_NBYTES, so latency is NBYTES cycles from accept to first out_valid.
- Completion edge Tc is where out_valid && out_ready is sampled high. in_ready is high from Tc onward.
  - The earliest next accept is edge Tc+1.
  - Minimum initiation interval is NBYTES+2 cycles with out_ready held high.
- A consumer holding out_ready low stalls indefinitely. Outputs do not change during the stall.
- in_valid is not registered early. A request arriving during RUN or DONE waits for IDLE; the producer holds it.
- result/cout/ovf are register outputs with no combinational path from inputs. in_ready, out_valid and busy decode directly from the state register.

## Test plan
- NBYTES=4, add, A=0x000000FF, B=0x00000001:
  - result = 0x00000100, cout = 0, ovf = 0;
  - out_valid rises exactly 4 cycles after accept.
- Add 0xFFFFFFFF + 0x00000001 gives result 0x00000000, cout 1, ovf 0. Add 0x7FFFFFFF + 0x00000001 gives 0x80000000, cout 0, ovf 1.
- Subtraction:
  - 0x00000005 − 0x00000007 gives 0xFFFFFFFE, cout 0 (borrow), ovf 0;
  - 0x80000000 − 0x00000001 gives 0x7FFFFFFF, cout 1, ovf 1.
- Backpressure:
  - hold out_ready = 0 for 10 cycles in DONE with a second in_valid pending;
  - result must stay stable, in_ready must stay 0 and the second op must not be accepted;
  - after out_ready = 1, the second op is accepted on the following edge.
- Reset during RUN: drive rst_n = 0 on RUN cycle 2.
  - The next cycle shows in_ready 1, out_valid 0, busy 0 and result 0x00000000.
  - The aborted result is never presented.
- Random regression with NBYTES = 2 and 16: 1000 random A, B, sub, out_ready patterns compared against a W-bit reference model for result, cout and ovf.

Source files
------------

// File: rtl/mbyte_add_seq.sv
// Serial multi-byte adder/subtractor: one cla_8bit reused across NBYTES clocks,
// carry registered between bytes, valid/ready handshakes on both sides.
module cla_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] sum,
  output logic       cout
);
  logic [7:0] g;
  logic [7:0] p;
  logic [8:0] c;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < 8; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum  = p ^ c[7:0];
    cout = c[8];
  end
endmodule

module mbyte_add_seq #(
  parameter int NBYTES = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] op_a,
  input  logic [8*NBYTES-1:0] op_b,
  input  logic                sub,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] result,
  output logic                cout,
  output logic                ovf,
  output logic                busy
);
  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [W-1:0]     res_q, res_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic [W-1:0]     a_q, a_d;
  logic [W-1:0]     b_q, b_d;

  logic [7:0] byte_a, byte_b, byte_sum;
  logic       byte_cout;

  always_comb begin
    byte_a = '0;
    byte_b = '0;
    for (int i = 0; i < NBYTES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        byte_a = a_q[8*i +: 8];
        byte_b = b_q[8*i +: 8];
      end
    end
  end

  cla_8bit u_cla (
    .a    (byte_a),
    .b    (byte_b),
    .cin  (carry_q),
    .sum  (byte_sum),
    .cout (byte_cout)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    res_d   = res_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    a_d     = a_q;
    b_d     = b_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = op_a;
          b_d     = sub ? ~op_b : op_b;
          carry_d = sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int i = 0; i < NBYTES; i++) begin
          if (idx_q == IDX_W'(i)) res_d[8*i +: 8] = byte_sum;
        end
        carry_d = byte_cout;
        if (idx_q == LAST) begin
          // b_q already holds ~B for subtraction, so one overflow rule covers both ops
          cout_d  = byte_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (byte_sum[7] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  // Operand registers are only meaningful in RUN, so they carry no reset
  always_ff @(posedge clk) begin
    a_q <= a_d;
    b_q <= b_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == RUN) || (state_q == DONE);
  assign result    = res_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
endmodule

// File: tb/tb_mbyte_add_seq.sv
// Bench for mbyte_add_seq: directed NBYTES=4 scenarios plus random regression
// on NBYTES=2 and NBYTES=16 instances against an arithmetic reference model.
module tb_mbyte_add_seq;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [127:0] r;
    logic         c;
    logic         o;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  // NBYTES=4 instance
  logic        in_valid4, in_ready4, sub4, out_valid4, out_ready4, cout4, ovf4, busy4;
  logic [31:0] op_a4, op_b4, res4;

  mbyte_add_seq #(.NBYTES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .op_a(op_a4), .op_b(op_b4), .sub(sub4), .out_valid(out_valid4),
    .out_ready(out_ready4), .result(res4), .cout(cout4), .ovf(ovf4), .busy(busy4)
  );

  // Shared random stimulus, steered to the NBYTES=2 or NBYTES=16 instance by sel
  logic         sel, rin_valid, rsub, rout_ready;
  logic [127:0] ra, rb;
  logic         in_ready2, out_valid2, cout2, ovf2, busy2;
  logic         in_ready16, out_valid16, cout16, ovf16, busy16;
  logic [15:0]  res2;
  logic [127:0] res16;
  logic         rin_ready, rout_valid, rcout, rovf;
  logic [127:0] rres;

  mbyte_add_seq #(.NBYTES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(rin_valid & ~sel), .in_ready(in_ready2),
    .op_a(ra[15:0]), .op_b(rb[15:0]), .sub(rsub), .out_valid(out_valid2),
    .out_ready(rout_ready & ~sel), .result(res2), .cout(cout2), .ovf(ovf2), .busy(busy2)
  );

  mbyte_add_seq #(.NBYTES(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(rin_valid & sel), .in_ready(in_ready16),
    .op_a(ra), .op_b(rb), .sub(rsub), .out_valid(out_valid16),
    .out_ready(rout_ready & sel), .result(res16), .cout(cout16), .ovf(ovf16), .busy(busy16)
  );

  assign rin_ready  = sel ? in_ready16  : in_ready2;
  assign rout_valid = sel ? out_valid16 : out_valid2;
  assign rcout      = sel ? cout16      : cout2;
  assign rovf       = sel ? ovf16       : ovf2;
  assign rres       = sel ? res16       : {112'b0, res2};

  // Reference: plain w-bit add or subtract; borrow and overflow from magnitudes and signs
  function automatic exp_t ref_model(input logic [127:0] a, input logic [127:0] b,
                                     input logic s, input int w);
    logic [128:0] mask, am, bm, sum;
    exp_t e;
    mask = (129'b1 << w) - 129'b1;
    am   = {1'b0, a} & mask;
    bm   = {1'b0, b} & mask;
    if (s) begin
      sum = (am - bm) & mask;
      e.c = (am >= bm);
      e.o = (am[w-1] != bm[w-1]) && (sum[w-1] != am[w-1]);
    end else begin
      sum = am + bm;
      e.c = sum[w];
      e.o = (am[w-1] == bm[w-1]) && (sum[w-1] != am[w-1]);
    end
    e.r = sum[127:0] & mask[127:0];
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op4(input logic [31:0] a, input logic [31:0] b, input logic s,
                     input string name);
    exp_t e;
    int   t, lat;
    sb.push_back(ref_model({96'b0, a}, {96'b0, b}, s, 32));
    t = 0;
    while (!in_ready4 && t < 50) begin tick(); t++; end
    in_valid4 = 1'b1; op_a4 = a; op_b4 = b; sub4 = s;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin tick(); lat++; end
    tests++;
    if (lat !== 4) begin
      fails++;
      $display("FAIL %s_latency: got %0d cycles, expected 4", name, lat);
    end
    e = sb.pop_front();
    tests++;
    if ({res4, cout4, ovf4} !== {e.r[31:0], e.c, e.o}) begin
      fails++;
      $display("FAIL %s: got r=%h c=%b o=%b, expected r=%h c=%b o=%b",
               name, res4, cout4, ovf4, e.r[31:0], e.c, e.o);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    tests++;
    if ({in_ready4, out_valid4, busy4, cout4, ovf4, res4} !== {5'b10000, 32'h0}) begin
      fails++;
      $display("FAIL reset_dut4: got rdy=%b vld=%b busy=%b c=%b o=%b r=%h, expected 1 0 0 0 0 0",
               in_ready4, out_valid4, busy4, cout4, ovf4, res4);
    end
    tests++;
    if ({in_ready2, out_valid2, busy2, cout2, ovf2, res2} !== {5'b10000, 16'h0}) begin
      fails++;
      $display("FAIL reset_dut2: got rdy=%b vld=%b busy=%b r=%h", in_ready2, out_valid2, busy2, res2);
    end
    tests++;
    if ({in_ready16, out_valid16, busy16, cout16, ovf16, res16} !== {5'b10000, 128'h0}) begin
      fails++;
      $display("FAIL reset_dut16: got rdy=%b vld=%b busy=%b r=%h", in_ready16, out_valid16, busy16, res16);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    op4(32'h000000FF, 32'h00000001, 1'b0, "add_ff_1");
    op4(32'hFFFFFFFF, 32'h00000001, 1'b0, "add_wrap");
    op4(32'h7FFFFFFF, 32'h00000001, 1'b0, "add_ovf");
    op4(32'h89ABCDEF, 32'h76543210, 1'b0, "add_mix");
  endtask

  task automatic test_sub();
    op4(32'h00000005, 32'h00000007, 1'b1, "sub_borrow");
    op4(32'h80000000, 32'h00000001, 1'b1, "sub_ovf");
    op4(32'h12345678, 32'h12345678, 1'b1, "sub_zero");
  endtask

  task automatic test_backpressure();
    exp_t        e;
    logic [31:0] hold;
    int          lat;
    sb.push_back(ref_model(128'h1111_2222, 128'h0F0F_0F0F, 1'b0, 32));
    in_valid4 = 1'b1; op_a4 = 32'h1111_2222; op_b4 = 32'h0F0F_0F0F; sub4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    lat = 0;
    while (!out_valid4 && lat < 100) begin tick(); lat++; end
    // Second request waits while the consumer stalls
    sb.push_back(ref_model(128'hA5A5_0000, 128'h0000_5A5A, 1'b1, 32));
    in_valid4 = 1'b1; op_a4 = 32'hA5A5_0000; op_b4 = 32'h0000_5A5A; sub4 = 1'b1;
    hold = res4;
    repeat (10) begin
      tick();
      tests++;
      if (res4 !== hold || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) begin
        fails++;
        $display("FAIL bp_stall: got r=%h rdy=%b vld=%b, expected r=%h rdy=0 vld=1",
                 res4, in_ready4, out_valid4, hold);
      end
    end
    e = sb.pop_front();
    tests++;
    if ({res4, cout4, ovf4} !== {e.r[31:0], e.c, e.o}) begin
      fails++;
      $display("FAIL bp_first: got r=%h c=%b o=%b, expected r=%h c=%b o=%b",
               res4, cout4, ovf4, e.r[31:0], e.c, e.o);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    tests++;
    if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0) begin
      fails++;
      $display("FAIL bp_release: got rdy=%b vld=%b, expected rdy=1 vld=0", in_ready4, out_valid4);
    end
    tick();
    in_valid4 = 1'b0;
    tests++;
    if (in_ready4 !== 1'b0 || busy4 !== 1'b1) begin
      fails++;
      $display("FAIL bp_accept2: got rdy=%b busy=%b, expected rdy=0 busy=1", in_ready4, busy4);
    end
    lat = 0;
    while (!out_valid4 && lat < 100) begin tick(); lat++; end
    e = sb.pop_front();
    tests++;
    if (lat !== 4 || {res4, cout4, ovf4} !== {e.r[31:0], e.c, e.o}) begin
      fails++;
      $display("FAIL bp_second: got lat=%0d r=%h c=%b o=%b, expected lat=4 r=%h c=%b o=%b",
               lat, res4, cout4, ovf4, e.r[31:0], e.c, e.o);
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
  endtask

  task automatic test_reset_run();
    logic seen;
    in_valid4 = 1'b1; op_a4 = 32'h1234_5678; op_b4 = 32'h1111_1111; sub4 = 1'b0;
    tick();
    in_valid4 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tests++;
    if ({in_ready4, out_valid4, busy4, res4} !== {3'b100, 32'h0}) begin
      fails++;
      $display("FAIL reset_run: got rdy=%b vld=%b busy=%b r=%h, expected 1 0 0 00000000",
               in_ready4, out_valid4, busy4, res4);
    end
    seen = 1'b0;
    out_ready4 = 1'b1;
    repeat (10) begin
      tick();
      if (out_valid4) seen = 1'b1;
    end
    out_ready4 = 1'b0;
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL reset_run_no_output: got out_valid seen=%b, expected 0", seen);
    end
  endtask

  task automatic test_random(input logic s, input int w, input int n);
    exp_t e;
    int   t;
    logic done;
    sel = s;
    tick();
    for (int k = 0; k < n; k++) begin
      ra   = {$urandom, $urandom, $urandom, $urandom};
      rb   = {$urandom, $urandom, $urandom, $urandom};
      rsub = 1'($urandom_range(0, 1));
      if (k % 8 == 0) rb = ra;
      if (k % 8 == 1) rb = {128{1'b1}};
      sb.push_back(ref_model(ra, rb, rsub, w));
      repeat ($urandom_range(0, 2)) tick();
      t = 0;
      while (!rin_ready && t < 50) begin tick(); t++; end
      rin_valid = 1'b1;
      tick();
      rin_valid = 1'b0;
      done = 1'b0;
      t = 0;
      while (!done && t < 200) begin
        rout_ready = 1'($urandom_range(0, 1));
        if (rout_valid && rout_ready) begin
          e = sb.pop_front();
          tests++;
          if ({rres, rcout, rovf} !== {e.r, e.c, e.o}) begin
            fails++;
            $display("FAIL rand_w%0d_%0d: a=%h b=%h sub=%b got r=%h c=%b o=%b, expected r=%h c=%b o=%b",
                     w, k, ra, rb, rsub, rres, rcout, rovf, e.r, e.c, e.o);
          end
          done = 1'b1;
        end
        tick();
        t++;
      end
      rout_ready = 1'b0;
      if (!done) begin
        tests++;
        fails++;
        $display("FAIL rand_w%0d_%0d_timeout: got no result in 200 cycles, expected one", w, k);
        void'(sb.pop_front());
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid4 = 1'b0; op_a4 = '0; op_b4 = '0; sub4 = 1'b0; out_ready4 = 1'b0;
    sel = 1'b0; rin_valid = 1'b0; rsub = 1'b0; rout_ready = 1'b0; ra = '0; rb = '0;
    tick();
    test_reset();
    test_add();
    test_sub();
    test_backpressure();
    test_reset_run();
    test_random(1'b0, 16, 1000);
    test_random(1'b1, 128, 1000);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
